tag_alloc_ctrl: RTL and testbench

Controller that owns the rename-tag free list (`tag_fifo`) and shares it between two clients: the rename stage, which allocates 1 or 2 tags per cycle, and the commit stage, which returns up to 2 tags per cycle. After reset it seeds the free list with every physical tag not initially mapped to an architectural register. It then arbitrates allocations against free-list occupancy and serialises returned tags into the single-write-port FIFO through a small return queue.

---
 rtl/tag_pkg.sv | 16 +
 rtl/tag_ret_queue.sv | 61 ++++++
 rtl/tag_alloc_ctrl.sv | 107 ++++++++++
 tb/tb_tag_alloc_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_pkg.sv
// rtl/tag_pkg.sv - shared types and default sizes for the rename-tag allocator
package tag_pkg;

    typedef logic [7:0] tag_t;

    localparam int NUM_TAGS  = 128;
    localparam int ARCH_REGS = 32;
    localparam int FIFO_CAP  = 128;
    localparam int RQ_DEPTH  = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } tac_state_t;

endpackage

// File: rtl/tag_ret_queue.sv
// rtl/tag_ret_queue.sv - 2-in/1-out circular buffer that serialises returned tags
module tag_ret_queue
    import tag_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             push,
    input  tag_t                   push_tag0,
    input  tag_t                   push_tag1,
    input  logic                   pop,
    output tag_t                   head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] free_cnt
);

    localparam int AW = $clog2(DEPTH);

    tag_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic [AW:0] wr_nxt;
    logic [AW:0] n_push;
    tag_t        first_tag;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign count    = wr_ptr - rd_ptr;
    assign empty    = (count == '0);
    assign free_cnt = (AW + 1)'(DEPTH) - count;
    assign head     = mem[rd_ptr[AW-1:0]];
    assign wr_nxt   = wr_ptr + (AW + 1)'(1);

    always_comb begin
        first_tag = push[0] ? push_tag0 : push_tag1;
        n_push    = (AW + 1)'(push[0]) + (AW + 1)'(push[1]);
    end

    always_ff @(posedge clk) begin
        if (push[0] || push[1]) begin
            mem[wr_ptr[AW-1:0]] <= first_tag;
        end
        if (push[0] && push[1]) begin
            mem[wr_nxt[AW-1:0]] <= push_tag1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_push;
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/tag_alloc_ctrl.sv
// rtl/tag_alloc_ctrl.sv - seeds the tag free list and shares it between rename and commit
module tag_alloc_ctrl #(
    parameter int NUM_TAGS  = tag_pkg::NUM_TAGS,
    parameter int ARCH_REGS = tag_pkg::ARCH_REGS,
    parameter int FIFO_CAP  = tag_pkg::FIFO_CAP,
    parameter int RQ_DEPTH  = tag_pkg::RQ_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alloc_valid,
    input  logic        alloc_two,
    output logic        alloc_grant,
    output logic [7:0]  alloc_tag0,
    output logic [7:0]  alloc_tag1,
    input  logic [1:0]  ret_valid,
    input  logic [7:0]  ret_tag0,
    input  logic [7:0]  ret_tag1,
    output logic        ret_ready,
    output logic        init_done,
    output logic [15:0] stall_cnt,
    output logic [7:0]  write_tag_source,
    output logic        write_tag,
    input  logic [7:0]  read_tag_dest_0,
    input  logic [7:0]  read_tag_dest_1,
    output logic        read_1_tag,
    output logic        read_2_tags,
    input  logic [7:0]  freespace
);

    import tag_pkg::*;

    localparam int QW = $clog2(RQ_DEPTH);

    tac_state_t  state;
    tag_t        init_ptr;
    logic        running;
    logic [8:0]  avail;
    logic [8:0]  need;
    logic [1:0]  q_push;
    logic        q_pop;
    logic        q_empty;
    tag_t        q_head;
    logic [QW:0] q_free;

    // Reset must silence the combinational handshakes in the very cycle it is raised.
    assign running = (state == RUN) && !reset;

    assign avail       = 9'(FIFO_CAP) - {1'b0, freespace};
    assign need        = alloc_two ? 9'd2 : 9'd1;
    assign alloc_grant = running && alloc_valid && (avail >= need);
    assign alloc_tag0  = alloc_grant ? read_tag_dest_0 : '0;
    assign alloc_tag1  = (alloc_grant && alloc_two) ? read_tag_dest_1 : '0;
    assign read_2_tags = alloc_grant && alloc_two;
    assign read_1_tag  = alloc_grant && !alloc_two;

    assign ret_ready = running && (q_free >= (QW + 1)'(2));
    assign q_push    = ret_ready ? ret_valid : 2'b00;
    assign q_pop     = (state == RUN) && !q_empty;

    tag_ret_queue #(
        .DEPTH(RQ_DEPTH)
    ) u_ret_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (q_push),
        .push_tag0(ret_tag0),
        .push_tag1(ret_tag1),
        .pop      (q_pop),
        .head     (q_head),
        .empty    (q_empty),
        .free_cnt (q_free)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= INIT;
            init_ptr         <= tag_t'(ARCH_REGS);
            write_tag        <= 1'b0;
            write_tag_source <= '0;
            init_done        <= 1'b0;
            stall_cnt        <= '0;
        end else begin
            init_done <= (state == RUN);
            case (state)
                INIT: begin
                    write_tag        <= 1'b1;
                    write_tag_source <= init_ptr;
                    init_ptr         <= init_ptr + 8'd1;
                    if (init_ptr == tag_t'(NUM_TAGS - 1)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    write_tag <= !q_empty;
                    if (!q_empty) begin
                        write_tag_source <= q_head;
                    end
                    if (alloc_valid && !alloc_grant && (stall_cnt != 16'hFFFF)) begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_tag_alloc_ctrl.sv
// tb/tb_tag_alloc_ctrl.sv - randomized self-checking bench for tag_alloc_ctrl
module tb_tag_alloc_ctrl;

    localparam int FIFO_CAP = 128;
    localparam int RQ_DEPTH = 4;
    localparam int INIT_LEN = 96;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid;
    logic        alloc_two;
    logic        alloc_grant;
    logic [7:0]  alloc_tag0;
    logic [7:0]  alloc_tag1;
    logic [1:0]  ret_valid;
    logic [7:0]  ret_tag0;
    logic [7:0]  ret_tag1;
    logic        ret_ready;
    logic        init_done;
    logic [15:0] stall_cnt;
    logic [7:0]  write_tag_source;
    logic        write_tag;
    logic [7:0]  read_tag_dest_0 = 8'h00;
    logic [7:0]  read_tag_dest_1 = 8'h00;
    logic        read_1_tag;
    logic        read_2_tags;
    logic [7:0]  freespace = 8'd128;

    always #5 clk = ~clk;

    tag_alloc_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .alloc_valid     (alloc_valid),
        .alloc_two       (alloc_two),
        .alloc_grant     (alloc_grant),
        .alloc_tag0      (alloc_tag0),
        .alloc_tag1      (alloc_tag1),
        .ret_valid       (ret_valid),
        .ret_tag0        (ret_tag0),
        .ret_tag1        (ret_tag1),
        .ret_ready       (ret_ready),
        .init_done       (init_done),
        .stall_cnt       (stall_cnt),
        .write_tag_source(write_tag_source),
        .write_tag       (write_tag),
        .read_tag_dest_0 (read_tag_dest_0),
        .read_tag_dest_1 (read_tag_dest_1),
        .read_1_tag      (read_1_tag),
        .read_2_tags     (read_2_tags),
        .freespace       (freespace)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Free-list FIFO seen by the DUT: contents change at the sample point, outputs publish at the edge.
    logic [7:0] env_q[$];
    always @(posedge clk) begin
        freespace       <= 8'(FIFO_CAP - env_q.size());
        read_tag_dest_0 <= (env_q.size() > 0) ? env_q[0] : 8'h00;
        read_tag_dest_1 <= (env_q.size() > 1) ? env_q[1] : 8'h00;
    end

    // Reference model state
    int         k          = 0;
    int         rst_cycles = 0;
    logic [7:0] rq[$];
    logic       exp_wr     = 1'b0;
    logic [7:0] exp_src    = 8'h00;
    int         exp_stall  = 0;
    logic [7:0] held[$];
    logic [7:0] wr_log[$];

    always @(negedge clk) begin : cmp
        bit run;
        bit regs_ok;
        bit exp_grant;
        bit exp_rr;
        int sz;
        int need;

        run       = !reset && (k >= INIT_LEN);
        regs_ok   = !(reset && (rst_cycles == 0));
        sz        = env_q.size();
        need      = alloc_two ? 2 : 1;
        exp_grant = run && alloc_valid && (sz >= need);
        exp_rr    = run && ((RQ_DEPTH - rq.size()) >= 2);

        if (regs_ok) begin
            if (reset || k == 0) begin
                check("wr_reset", write_tag, 0);
                check("src_reset", write_tag_source, 0);
                check("init_done_reset", init_done, 0);
                check("stall_reset", stall_cnt, 0);
            end else begin
                if (k <= INIT_LEN) begin
                    check("seed_wr", write_tag, 1);
                    check("seed_src", write_tag_source, 8'(31 + k));
                end else begin
                    check("ret_wr", write_tag, exp_wr);
                    if (exp_wr) check("ret_src", write_tag_source, exp_src);
                end
                check("init_done", init_done, k > INIT_LEN);
                check("stall_cnt", stall_cnt, exp_stall);
            end
        end
        check("grant", alloc_grant, exp_grant);
        check("ret_ready", ret_ready, exp_rr);
        check("read_2", read_2_tags, exp_grant && alloc_two);
        check("read_1", read_1_tag, exp_grant && !alloc_two);
        if (exp_grant) begin
            check("tag0", alloc_tag0, env_q[0]);
            if (alloc_two) check("tag1", alloc_tag1, env_q[1]);
        end

        if (write_tag === 1'b1) wr_log.push_back(write_tag_source);

        if (reset) begin
            rq.delete();
            env_q.delete();
            exp_wr    = 1'b0;
            exp_stall = 0;
            k         = 0;
            rst_cycles++;
        end else begin
            rst_cycles = 0;
            if (run) begin
                if (alloc_valid && !exp_grant && exp_stall < 16'hFFFF) exp_stall++;
                exp_wr = (rq.size() != 0);
                if (exp_wr) exp_src = rq.pop_front();
                if (exp_rr) begin
                    if (ret_valid[0]) rq.push_back(ret_tag0);
                    if (ret_valid[1]) rq.push_back(ret_tag1);
                end
                if (exp_grant) begin
                    held.push_back(env_q[0]);
                    if (alloc_two) held.push_back(env_q[1]);
                end
            end
            if (read_2_tags === 1'b1 && env_q.size() >= 2) begin
                void'(env_q.pop_front());
                void'(env_q.pop_front());
            end else if (read_1_tag === 1'b1 && env_q.size() >= 1) begin
                void'(env_q.pop_front());
            end
            if (write_tag === 1'b1) begin
                check("fifo_room", env_q.size() < FIFO_CAP, 1);
                if (env_q.size() < FIFO_CAP) env_q.push_back(write_tag_source);
            end
            k++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0;
        alloc_two   = 1'b0;
        ret_valid   = 2'b00;
        ret_tag0    = 8'h00;
        ret_tag1    = 8'h00;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    endtask

    initial begin : stim
        int         guard;
        logic [1:0] pat;

        reset = 1'b1;
        idle_inputs();
        repeat (3) cyc();
        reset = 1'b0;
        wr_log.delete();
        repeat (INIT_LEN + 1) cyc();
        sample();
        check("init_done_at_97", init_done, 1);
        check("ret_ready_after_init", ret_ready, 1);
        check("seed_count", wr_log.size(), 96);
        check("seed_first", (wr_log.size() > 0) ? wr_log[0] : 8'hxx, 8'h20);
        check("seed_last", (wr_log.size() > 95) ? wr_log[95] : 8'hxx, 8'h7F);

        cyc();
        alloc_valid = 1'b1;
        alloc_two   = 1'b1;
        sample();
        check("pair_grant", alloc_grant, 1);
        check("pair_tag0", alloc_tag0, 8'h20);
        check("pair_tag1", alloc_tag1, 8'h21);
        check("pair_read2", read_2_tags, 1);
        check("pair_read1", read_1_tag, 0);

        cyc();
        guard = 0;
        while (env_q.size() > 1 && guard < 300) begin
            alloc_valid = 1'b1;
            alloc_two   = (env_q.size() >= 3);
            cyc();
            guard++;
        end
        check("drain_done", env_q.size(), 1);
        alloc_valid = 1'b1;
        alloc_two   = 1'b1;
        sample();
        check("short_grant", alloc_grant, 0);
        check("short_read2", read_2_tags, 0);
        check("short_read1", read_1_tag, 0);
        check("short_stall0", stall_cnt, 0);
        repeat (3) cyc();
        alloc_two = 1'b0;
        sample();
        check("stall_after_3", stall_cnt, 3);
        check("single_grant", alloc_grant, 1);
        check("single_read1", read_1_tag, 1);
        cyc();
        idle_inputs();
        cyc();

        wr_log.delete();
        ret_valid = 2'b11;
        ret_tag0  = 8'h05;
        ret_tag1  = 8'h06;
        cyc();
        ret_tag0  = 8'h07;
        ret_tag1  = 8'h08;
        cyc();
        idle_inputs();
        sample();
        check("rq_backpressure", ret_ready, 0);
        check("rq_first_wr", write_tag, 1);
        check("rq_first_src", write_tag_source, 8'h05);
        repeat (6) cyc();
        sample();
        check("rq_count", wr_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("rq_order", (wr_log.size() > i) ? wr_log[i] : 8'hxx, 8'(5 + i));
        end

        cyc();
        wr_log.delete();
        ret_valid = 2'b10;
        ret_tag0  = 8'h99;
        ret_tag1  = 8'h44;
        cyc();
        idle_inputs();
        repeat (4) cyc();
        sample();
        check("slot1_count", wr_log.size(), 1);
        check("slot1_tag", (wr_log.size() > 0) ? wr_log[0] : 8'hxx, 8'h44);

        for (int n = 0; n < 1500; n++) begin
            cyc();
            alloc_valid = ($urandom_range(0, 3) != 0);
            alloc_two   = 1'($urandom_range(0, 1));
            ret_valid   = 2'b00;
            ret_tag0    = 8'($urandom);
            ret_tag1    = 8'($urandom);
            if (held.size() > 0 && (ret_ready === 1'b1 || $urandom_range(0, 15) == 0)) begin
                pat = 2'($urandom_range(1, 3));
                if (pat[0]) ret_tag0 = held.pop_front();
                if (pat[1]) begin
                    if (held.size() > 0) ret_tag1 = held.pop_front();
                    else pat[1] = 1'b0;
                end
                ret_valid = pat;
            end
        end

        cyc();
        idle_inputs();
        reset = 1'b1;
        held.delete();
        sample();
        check("run_reset_grant", alloc_grant, 0);
        check("run_reset_ready", ret_ready, 0);
        cyc();
        reset = 1'b0;
        wr_log.delete();
        repeat (40) cyc();
        reset = 1'b1;
        sample();
        check("init_reset_grant", alloc_grant, 0);
        cyc();
        sample();
        check("init_reset_wr", write_tag, 0);
        check("init_reset_src", write_tag_source, 0);
        check("init_reset_done", init_done, 0);
        check("init_reset_stall", stall_cnt, 0);
        cyc();
        reset = 1'b0;
        wr_log.delete();
        repeat (3) cyc();
        sample();
        check("reseed_first", (wr_log.size() > 0) ? wr_log[0] : 8'hxx, 8'h20);
        repeat (100) cyc();
        sample();
        check("reseed_done", init_done, 1);

        summary();
        $finish;
    end

    initial begin : watchdog
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got timeout, want bench completion");
        summary();
        $finish;
    end

endmodule
